// File: rtl/icache_fetch_unit.sv
// Direct-mapped read-only instruction cache. Hits are answered in the lookup cycle.
// A miss stalls fetch while the FSM refills one full line over a valid/ready handshake.
module icache_fetch_unit #(
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  input  logic [ADDR_WIDTH-1:0]        req_addr,
  input  logic                         invalidate,
  output logic                         resp_valid,
  output logic [31:0]                  resp_inst,
  output logic                         stall,
  output logic                         mem_req_valid,
  output logic [ADDR_WIDTH-1:0]        mem_req_addr,
  input  logic                         mem_req_ready,
  input  logic                         mem_resp_valid,
  input  logic [32*WORDS_PER_LINE-1:0] mem_resp_data,
  output logic [31:0]                  hit_count,
  output logic [31:0]                  miss_count,
  output logic [1:0]                   o_dbg_state
);

  localparam int WORD_BITS  = $clog2(WORDS_PER_LINE);
  localparam int INDEX_BITS = $clog2(NUM_LINES);
  localparam int LINE_LSB   = WORD_BITS + 2;
  localparam int TAG_BITS   = ADDR_WIDTH - LINE_LSB - INDEX_BITS;
  localparam int LINE_BITS  = 32 * WORDS_PER_LINE;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_REQ  = 2'd1,
    S_MEM_WAIT = 2'd2
  } state_t;

  state_t r_state, w_next;

  logic [NUM_LINES-1:0]  r_valid;
  logic [TAG_BITS-1:0]   r_tags [NUM_LINES];
  logic [LINE_BITS-1:0]  r_data [NUM_LINES];
  logic [ADDR_WIDTH-1:0] r_miss_addr;
  logic [31:0]           r_hit_count;
  logic [31:0]           r_miss_count;

  logic [1:0]            w_unused_offset;
  logic [WORD_BITS-1:0]  w_word;
  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_BITS-1:0]   w_tag;
  logic [INDEX_BITS-1:0] w_miss_index;
  logic [TAG_BITS-1:0]   w_miss_tag;
  logic [ADDR_WIDTH-1:0] w_line_addr;
  logic                  w_hit;
  logic                  w_lookup;
  logic                  w_install;

  assign w_unused_offset = req_addr[1:0];
  assign w_word          = req_addr[2 +: WORD_BITS];
  assign w_index         = req_addr[LINE_LSB +: INDEX_BITS];
  assign w_tag           = req_addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign w_miss_index    = r_miss_addr[LINE_LSB +: INDEX_BITS];
  assign w_miss_tag      = r_miss_addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign w_line_addr     = {req_addr[ADDR_WIDTH-1:LINE_LSB], {LINE_LSB{1'b0}}};
  assign w_hit           = r_valid[w_index] && (r_tags[w_index] == w_tag);
  assign w_lookup        = (r_state == S_IDLE) && req_valid && !reset;
  assign w_install       = (r_state == S_MEM_WAIT) && mem_resp_valid && !reset;

  assign resp_inst    = r_data[w_index][w_word*32 +: 32];
  assign mem_req_addr = r_miss_addr;
  assign hit_count    = r_hit_count;
  assign miss_count   = r_miss_count;
  assign o_dbg_state  = r_state;

  // mem_req_valid/ready: a request transfers on the cycle both are high;
  // mem_req_valid and mem_req_addr hold steady until then.
  always_comb begin
    w_next        = r_state;
    resp_valid    = 1'b0;
    stall         = 1'b0;
    mem_req_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_hit) begin
            resp_valid = 1'b1;
          end else begin
            stall  = 1'b1;
            w_next = S_MEM_REQ;
          end
        end
      end
      S_MEM_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        if (mem_req_ready) w_next = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        stall = 1'b1;
        if (mem_resp_valid) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Reset cycle presents a quiet interface whatever state is being left.
    if (reset) begin
      resp_valid    = 1'b0;
      stall         = 1'b0;
      mem_req_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_miss_addr  <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_lookup) begin
        if (w_hit) begin
          r_hit_count <= r_hit_count + 32'd1;
        end else begin
          r_miss_count <= r_miss_count + 32'd1;
          r_miss_addr  <= w_line_addr;
        end
      end
      // Invalidate beats a coincident install so the refilled line stays invalid.
      if (invalidate) begin
        r_valid <= '0;
      end else if (w_install) begin
        r_valid[w_miss_index] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_install) begin
      r_tags[w_miss_index] <= w_miss_tag;
      r_data[w_miss_index] <= mem_resp_data;
    end
  end

endmodule

// File: tb/tb_icache_fetch_unit.sv
// Directed bench for icache_fetch_unit: refill timing, hits, conflicts,
// handshake back-pressure, invalidate interactions and reset mid-refill.
module tb_icache_fetch_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic [31:0]  req_addr;
  logic         invalidate;
  logic         resp_valid;
  logic [31:0]  resp_inst;
  logic         stall;
  logic         mem_req_valid;
  logic [31:0]  mem_req_addr;
  logic         mem_req_ready;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
  logic [1:0]   o_dbg_state;

  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int exp_hits   = 0;
  int exp_misses = 0;

  icache_fetch_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .invalidate(invalidate), .resp_valid(resp_valid), .resp_inst(resp_inst),
    .stall(stall), .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .hit_count(hit_count), .miss_count(miss_count),
    .o_dbg_state(o_dbg_state)
  );

  always #5 clk = ~clk;

  // Memory contents model: instruction at byte address a is (a << 5) + 0x13.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a << 5) + 32'h13;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] base);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = inst_of(base + 32'(4*i));
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic check_counts();
    chk("hit_count", hit_count, 32'(exp_hits));
    chk("miss_count", miss_count, 32'(exp_misses));
  endtask

  // Full miss: IDLE lookup, ready_delay cycles of back-pressure, handshake,
  // lat cycles in MEM_WAIT with the response on the last one.
  task automatic do_miss(input logic [31:0] addr, input int ready_delay,
                         input int lat, input logic inv_at_resp);
    logic [31:0] line_addr;
    line_addr = addr & ~32'hF;
    req_valid = 1'b1;
    req_addr  = addr;
    sample();
    chk("miss_stall", {31'd0, stall}, 32'd1);
    chk("miss_resp_valid", {31'd0, resp_valid}, 32'd0);
    exp_misses++;
    tick();
    for (int d = 0; d < ready_delay; d++) begin
      mem_req_ready = 1'b0;
      sample();
      chk("held_req_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("held_req_addr", mem_req_addr, line_addr);
      chk("held_stall", {31'd0, stall}, 32'd1);
      tick();
    end
    mem_req_ready = 1'b1;
    sample();
    chk("req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("req_addr", mem_req_addr, line_addr);
    tick();
    mem_req_ready = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      if (i == lat) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = line_of(line_addr);
        invalidate     = inv_at_resp;
      end
      sample();
      chk("wait_stall", {31'd0, stall}, 32'd1);
      chk("wait_req_valid", {31'd0, mem_req_valid}, 32'd0);
      tick();
    end
    mem_resp_valid = 1'b0;
    invalidate     = 1'b0;
  endtask

  task automatic lookup_hit(input logic [31:0] addr);
    req_valid = 1'b1;
    req_addr  = addr;
    exp_q.push_back(inst_of(addr));
    sample();
    chk("hit_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("hit_stall", {31'd0, stall}, 32'd0);
    if (exp_q.size() > 0) chk("hit_resp_inst", resp_inst, exp_q.pop_front());
    exp_hits++;
    tick();
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b1; req_addr = '0; invalidate = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    sample();
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    tick();
    tick();
    reset = 1'b0; req_valid = 1'b0;
    check_counts();
    chk("rst_state", {30'd0, o_dbg_state}, 32'd0);

    // Cold miss, latency 3: five stalled cycles, then hit.
    do_miss(32'h00, 0, 3, 1'b0);
    lookup_hit(32'h00);
    check_counts();
    lookup_hit(32'h04);
    lookup_hit(32'h08);
    lookup_hit(32'h0C);
    check_counts();

    // Idle cycle: no response, no stall, no counting.
    req_valid = 1'b0;
    sample();
    chk("idle_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("idle_stall", {31'd0, stall}, 32'd0);
    tick();
    check_counts();

    // Conflict on index 0, then re-miss with ready held low for 4 cycles.
    do_miss(32'h100, 0, 2, 1'b0);
    lookup_hit(32'h104);
    do_miss(32'h000, 4, 2, 1'b0);
    lookup_hit(32'h008);
    check_counts();

    // Invalidate coincident with install: FSM returns, line stays invalid.
    do_miss(32'h40, 0, 2, 1'b1);
    req_valid = 1'b0;
    sample();
    chk("inv_state_idle", {30'd0, o_dbg_state}, 32'd0);
    chk("inv_idle_stall", {31'd0, stall}, 32'd0);
    tick();
    do_miss(32'h44, 0, 1, 1'b0);
    check_counts();
    lookup_hit(32'h44);

    // Invalidate in IDLE: same-cycle lookup still hits, next one misses.
    invalidate = 1'b1;
    lookup_hit(32'h48);
    invalidate = 1'b0;
    do_miss(32'h48, 1, 1, 1'b0);
    lookup_hit(32'h4C);
    check_counts();

    // Reset during MEM_WAIT followed by a late response.
    req_valid = 1'b1; req_addr = 32'h80;
    tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    sample();
    chk("pre_rst_wait", {30'd0, o_dbg_state}, 32'd2);
    tick();
    reset = 1'b1; req_valid = 1'b0;
    sample();
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    chk("midrst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    tick();
    reset = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = line_of(32'h80);
    sample();
    chk("post_rst_state", {30'd0, o_dbg_state}, 32'd0);
    tick();
    mem_resp_valid = 1'b0;
    exp_hits = 0; exp_misses = 0;
    check_counts();
    chk("post_rst_state2", {30'd0, o_dbg_state}, 32'd0);
    req_valid = 1'b1; req_addr = 32'h00;
    sample();
    chk("post_rst_miss_stall", {31'd0, stall}, 32'd1);
    chk("post_rst_miss_resp", {31'd0, resp_valid}, 32'd0);
    tick();
    exp_misses = 1;
    check_counts();
    req_valid = 1'b0;
    req_addr = 32'h80;
    reset = 1'b1;
    tick();
    reset = 1'b0; req_valid = 1'b1;
    sample();
    chk("late_resp_not_installed", {31'd0, stall}, 32'd1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
